rv32_ifetch: RTL and testbench

RV32_IFETCH -- requirements
Module: rv32_ifetch

---
 rtl/rv32_ifetch.sv | 128 ++++++++++++
 tb/tb_rv32_ifetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_ifetch.sv
// RV32 instruction fetch unit: a fetch PC, an in-order request stream to
// instruction memory, and a small prefetch FIFO feeding decode.
// Requests are credit-limited so that every live response has a FIFO slot.
// On a redirect the FIFO is flushed, and responses to older requests are
// counted down and discarded.
module rv32_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;
    typedef logic [2:0]    cnt_t;
    typedef logic [PW-1:0] ptr_t;
    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [31:0] pc_q, pc_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    cnt_t        cnt_q, cnt_d;
    cnt_t        outs_q, outs_d;
    cnt_t        drop_q, drop_d;
    ptr_t        head_q, head_d;
    logic        started_q;
    logic [31:0] data_q [DEPTH];
    logic [31:0] addr_q [DEPTH];

    logic        accept;
    logic        rsp_live;
    logic        push;
    logic        pop;
    ptr_t        tail;
    cnt_t        credit;

    assign accept   = imem_req_valid & imem_req_ready;
    assign rsp_live = imem_rsp_valid & (drop_q == '0);
    assign push     = rsp_live & ~redirect_valid;
    assign pop      = inst_valid & inst_ready;
    assign tail     = head_q + cnt_q[PW-1:0];
    assign credit   = cnt_q + outs_q + drop_q;

    assign imem_req_valid = started_q & ~redirect_valid & (credit < DEPTH_C);
    assign imem_req_addr  = pc_q & 32'hFFFF_FFFC;
    assign inst_valid     = (cnt_q != '0);
    assign inst_data      = data_q[head_q];
    assign inst_pc        = addr_q[head_q];

    // Next-state for fetch PC, FIFO occupancy and in-flight bookkeeping.
    // Live responses always belong to consecutive addresses starting at the
    // last redirect target, so a single rsp_pc register replaces a per-request
    // address queue.
    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        cnt_d    = cnt_q;
        outs_d   = outs_q;
        drop_d   = drop_q;
        head_d   = head_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc & 32'hFFFF_FFFC;
            rsp_pc_d = redirect_pc & 32'hFFFF_FFFC;
            cnt_d    = '0;
            head_d   = '0;
            outs_d   = '0;
            drop_d   = outs_q + drop_q - {2'b00, imem_rsp_valid};
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + ptr_t'(1);
            end
            cnt_d  = cnt_q + {2'b00, push} - {2'b00, pop};
            outs_d = outs_q + {2'b00, accept} - {2'b00, rsp_live};
            drop_d = drop_q - {2'b00, imem_rsp_valid & (drop_q != '0)};
        end
    end

    // Control state registers; requests are held off until the first edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            rsp_pc_q  <= RESET_PC;
            cnt_q     <= '0;
            outs_q    <= '0;
            drop_q    <= '0;
            head_q    <= '0;
            started_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            rsp_pc_q  <= rsp_pc_d;
            cnt_q     <= cnt_d;
            outs_q    <= outs_d;
            drop_q    <= drop_d;
            head_q    <= head_d;
            started_q <= 1'b1;
        end
    end

    // Prefetch FIFO storage: each live response is written with its fetch address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else if (push) begin
            data_q[tail] <= imem_rsp_data;
            addr_q[tail] <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_rv32_ifetch.sv
// Scoreboard bench for rv32_ifetch: a driver with an in-order memory model
// pushes expected instructions; a monitor pops and compares on each handshake.
module tb_rv32_ifetch;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    rv32_ifetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bus_addr;
        logic [31:0] model_pc;
        int unsigned epoch;
        int unsigned due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    mreq_t       memq[$];
    inst_t       expq[$];
    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned cyc;
    int unsigned epoch;
    int unsigned last_due;
    int unsigned lat_lo;
    int unsigned lat_hi;
    int unsigned n_accept;
    logic [31:0] exp_fetch;
    bit          in_reset;
    bit          prev_stall;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus the memory and instruction-stream model.
    task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc, input bit ir);
        bit          rsp_on;
        mreq_t       m;
        int unsigned due;
        @(negedge clk);
        imem_req_ready = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = ir;
        rsp_on = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rsp_valid = rsp_on;
        imem_rsp_data  = rsp_on ? mem_word(memq[0].bus_addr) : $urandom;
        #3;
        if (rsp_on) begin
            m = memq.pop_front();
            if (m.epoch == epoch && !rv)
                expq.push_back('{pc: m.model_pc, data: mem_word(m.model_pc)});
        end
        if (imem_req_valid && imem_req_ready) begin
            n_accept++;
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due < last_due) due = last_due;
            last_due = due;
            memq.push_back('{bus_addr: imem_req_addr, model_pc: exp_fetch, epoch: epoch, due: due});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (rv) begin
            epoch++;
            expq.delete();
            exp_fetch = rpc & 32'hFFFF_FFFC;
        end
        cyc++;
    endtask

    task automatic enter_reset();
        in_reset       = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        reset          = 1'b0;
        #1;
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        memq.delete();
        expq.delete();
        epoch++;
        exp_fetch = RESET_PC;
        last_due  = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("req_valid_at_release", 32'(imem_req_valid), 32'd0);
        in_reset = 1'b0;
    endtask

    // Monitor: compares the DUT against the scoreboard once per cycle.
    initial begin
        inst_t e;
        forever begin
            @(negedge clk);
            #2;
            if (in_reset) begin
                prev_stall = 1'b0;
            end else begin
                if (imem_req_valid) begin
                    check("req_credit", 32'(memq.size() + expq.size() < DEPTH), 32'd1);
                    check("req_addr_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
                end
                if (imem_req_valid && imem_req_ready)
                    check("req_addr", imem_req_addr, exp_fetch);
                if (prev_stall && !redirect_valid) begin
                    check("req_hold_valid", 32'(imem_req_valid), 32'd1);
                    check("req_hold_addr", imem_req_addr, prev_addr);
                end
                prev_stall = imem_req_valid && !imem_req_ready;
                prev_addr  = imem_req_addr;
                if (inst_valid && inst_ready) begin
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_inst: got pc %h data %h expected none", inst_pc, inst_data);
                    end else begin
                        e = expq.pop_front();
                        check("inst_pc", inst_pc, e.pc);
                        check("inst_data", inst_data, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          reached;
        bit          rv;
        logic [31:0] tgt;
        n_cmp = 0; n_err = 0; cyc = 0; epoch = 0; last_due = 0;
        lat_lo = 1; lat_hi = 1; n_accept = 0;
        exp_fetch = RESET_PC; prev_stall = 1'b0; prev_addr = '0;
        redirect_pc = '0; imem_rsp_data = '0;
        enter_reset();

        // Decode stalled from the start: exactly DEPTH requests, then idle.
        n_accept = 0;
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0);
        check("stall_accepts", n_accept, DEPTH);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        repeat (12) step(1'b1, 1'b0, 32'h0, 1'b1);

        // Memory not ready for 3 cycles: request must be held.
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect with two requests in flight.
        lat_lo = 3; lat_hi = 3;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (memq.size() == 2) reached = 1'b1;
            else step(1'b1, 1'b0, 32'h0, 1'b1);
        end
        check("two_outstanding_reached", 32'(reached), 32'd1);
        step(1'b1, 1'b1, 32'h0000_0203, 1'b1);
        lat_lo = 1; lat_hi = 2;
        repeat (15) step(1'b1, 1'b0, 32'h0, 1'b1);

        // Fetch PC wrap-around.
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (12) step(1'b1, 1'b0, 32'h0, 1'b1);

        // Back-to-back redirects.
        step(1'b1, 1'b1, 32'h0000_1000, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h0000_2001, 1'b1);
        step(1'b1, 1'b1, 32'h0000_3002, 1'b0);
        step(1'b1, 1'b1, 32'h0000_4000, 1'b1);
        repeat (12) step(1'b1, 1'b0, 32'h0, 1'b1);

        // Randomized traffic.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 800; i++) begin
            rv  = ($urandom_range(19, 0) == 0);
            tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
            step($urandom_range(3, 0) != 0, rv, tgt, $urandom_range(9, 0) < 7);
        end

        // Reset with the buffer full.
        lat_lo = 1; lat_hi = 1;
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);
        check("pre_reset_full", 32'(inst_valid), 32'd1);
        @(negedge clk);
        #2;
        enter_reset();
        lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 200; i++) begin
            rv  = ($urandom_range(15, 0) == 0);
            step($urandom_range(3, 0) != 0, rv, $urandom, $urandom_range(9, 0) < 6);
        end

        // Drain: no new requests, decode always ready.
        repeat (30) step(1'b0, 1'b0, 32'h0, 1'b1);
        check("drain_expq_empty", expq.size(), 32'd0);
        check("drain_memq_empty", memq.size(), 32'd0);
        check("drain_inst_valid", 32'(inst_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
